// File: rtl/ysyx_25030093_csr_pkg.sv
// Shared CSR definitions: addresses, trap cause codes, mstatus bit layout.
package ysyx_25030093_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // MPP is hardwired to machine mode; only MIE and MPIE are live bits.
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] r;
        r               = 32'h0000_1800;
        r[MSTATUS_MIE]  = mie;
        r[MSTATUS_MPIE] = mpie;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_25030093_csr_cnt64.sv
// 64-bit counter with independently writable halves. A write to one half
// overrides that half's next value; the other half still takes the carry.
module ysyx_25030093_csr_cnt64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] cnt_r;
    logic [63:0] sum_s;
    logic [31:0] lo_next_s;
    logic [31:0] hi_next_s;

    // Next-value selection: increment with carry, then per-half write override.
    always_comb begin
        sum_s = cnt_r + {63'd0, inc};
        if (wr_lo) begin
            lo_next_s = wdata;
        end else begin
            lo_next_s = sum_s[31:0];
        end
        if (wr_hi) begin
            hi_next_s = wdata;
        end else begin
            hi_next_s = sum_s[63:32];
        end
    end

    // Counter state; reset dominates any write or increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 64'd0;
        end else begin
            cnt_r <= {hi_next_s, lo_next_s};
        end
    end

    assign count = cnt_r;

endmodule

// File: rtl/ysyx_25030093_csr_file.sv
// Machine-mode CSR file: combinational read, edge-committed writes,
// ecall/mret trap state and the mcycle/minstret counters.
module ysyx_25030093_csr_file
    import ysyx_25030093_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MVENDORID = 32'h7973_7978,
    parameter logic [31:0] MARCHID   = 32'd25030093
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] csr_addr,
    input  logic        csr_wen,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_data,
    output logic        csr_illegal,
    input  logic        ecall,
    input  logic        mret,
    input  logic [31:0] pc,
    input  logic        inst_retire,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic        mie_r;
    logic        mpie_r;
    logic [31:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic [63:0] mcycle_s;
    logic [63:0] minstret_s;

    logic        mapped_s;
    logic        read_only_s;
    logic        wen_ok_s;
    logic        wr_mstatus_s;
    logic        wr_mtvec_s;
    logic        wr_mscratch_s;
    logic        wr_mepc_s;
    logic        wr_mcause_s;
    logic        wr_mcycle_s;
    logic        wr_mcycleh_s;
    logic        wr_minstret_s;
    logic        wr_minstreth_s;

    // Address decode and combinational read mux (pre-edge state).
    always_comb begin
        csr_data    = 32'd0;
        mapped_s    = 1'b1;
        read_only_s = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:   csr_data = mstatus_pack(mie_r, mpie_r);
            CSR_MTVEC:     csr_data = mtvec_r;
            CSR_MSCRATCH:  csr_data = mscratch_r;
            CSR_MEPC:      csr_data = mepc_r;
            CSR_MCAUSE:    csr_data = mcause_r;
            CSR_MCYCLE:    csr_data = mcycle_s[31:0];
            CSR_MCYCLEH:   csr_data = mcycle_s[63:32];
            CSR_MINSTRET:  csr_data = minstret_s[31:0];
            CSR_MINSTRETH: csr_data = minstret_s[63:32];
            CSR_MVENDORID: begin
                csr_data    = MVENDORID;
                read_only_s = 1'b1;
            end
            CSR_MARCHID: begin
                csr_data    = MARCHID;
                read_only_s = 1'b1;
            end
            default: begin
                csr_data = 32'd0;
                mapped_s = 1'b0;
            end
        endcase
    end

    // Write strobes; trap events take their registers away from csr_wen.
    always_comb begin
        csr_illegal    = (!mapped_s) || (csr_wen && read_only_s);
        wen_ok_s       = csr_wen && mapped_s && !read_only_s;
        wr_mstatus_s   = wen_ok_s && (csr_addr == CSR_MSTATUS) && !ecall && !mret;
        wr_mtvec_s     = wen_ok_s && (csr_addr == CSR_MTVEC);
        wr_mscratch_s  = wen_ok_s && (csr_addr == CSR_MSCRATCH);
        wr_mepc_s      = wen_ok_s && (csr_addr == CSR_MEPC) && !ecall;
        wr_mcause_s    = wen_ok_s && (csr_addr == CSR_MCAUSE) && !ecall;
        wr_mcycle_s    = wen_ok_s && (csr_addr == CSR_MCYCLE);
        wr_mcycleh_s   = wen_ok_s && (csr_addr == CSR_MCYCLEH);
        wr_minstret_s  = wen_ok_s && (csr_addr == CSR_MINSTRET);
        wr_minstreth_s = wen_ok_s && (csr_addr == CSR_MINSTRETH);
    end

    // Redirect target: trap vector (forced word-aligned) on ecall, else mepc.
    always_comb begin
        redirect = ecall | mret;
        if (ecall) begin
            redirect_pc = {mtvec_r[31:2], 2'b00};
        end else begin
            redirect_pc = mepc_r;
        end
    end

    // mstatus interrupt-enable stack: ecall pushes, mret pops, then CSR write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mie_r  <= 1'b0;
            mpie_r <= 1'b0;
        end else if (ecall) begin
            mpie_r <= mie_r;
            mie_r  <= 1'b0;
        end else if (mret) begin
            mie_r  <= mpie_r;
            mpie_r <= 1'b1;
        end else if (wr_mstatus_s) begin
            mie_r  <= csr_wdata[MSTATUS_MIE];
            mpie_r <= csr_wdata[MSTATUS_MPIE];
        end else begin
            mie_r  <= mie_r;
            mpie_r <= mpie_r;
        end
    end

    // Trap-capture registers: ecall overrides software writes to mepc/mcause.
    always_ff @(posedge clk) begin
        if (reset) begin
            mepc_r   <= 32'd0;
            mcause_r <= 32'd0;
        end else if (ecall) begin
            mepc_r   <= pc & 32'hFFFF_FFFC;
            mcause_r <= MCAUSE_ECALL_M;
        end else begin
            if (wr_mepc_s) begin
                mepc_r <= csr_wdata & 32'hFFFF_FFFC;
            end
            if (wr_mcause_s) begin
                mcause_r <= csr_wdata;
            end
        end
    end

    // Plain software-owned registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtvec_r    <= MTVEC_RST;
            mscratch_r <= 32'd0;
        end else begin
            if (wr_mtvec_s) begin
                mtvec_r <= csr_wdata;
            end
            if (wr_mscratch_s) begin
                mscratch_r <= csr_wdata;
            end
        end
    end

    ysyx_25030093_csr_cnt64 u_mcycle (
        .clk   (clk),
        .reset (reset),
        .inc   (1'b1),
        .wr_lo (wr_mcycle_s),
        .wr_hi (wr_mcycleh_s),
        .wdata (csr_wdata),
        .count (mcycle_s)
    );

    ysyx_25030093_csr_cnt64 u_minstret (
        .clk   (clk),
        .reset (reset),
        .inc   (inst_retire),
        .wr_lo (wr_minstret_s),
        .wr_hi (wr_minstreth_s),
        .wdata (csr_wdata),
        .count (minstret_s)
    );

endmodule
